// File: rtl/noc_pkg.sv
// Shared flit layout, credit type and flit packing for the NoC injection and receive stages.
package noc_pkg;

  localparam int NOC_DATA_W = 64;
  localparam int NOC_DEST_W = 4;
  localparam int FLIT_W     = 71;

  localparam int VALID_BIT  = 70;
  localparam int TAIL_BIT   = 69;
  localparam int DEST_MSB   = 68;
  localparam int DEST_LSB   = 65;
  localparam int VC_BIT     = 64;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef struct packed {
    logic valid;
    logic vc;
  } credit_t;

  // Every result travels as a single-flit packet, so head and tail coincide.
  function automatic flit_t pack_flit(input logic [NOC_DEST_W-1:0] dest,
                                      input logic                  vc,
                                      input logic [NOC_DATA_W-1:0] data);
    flit_t f;
    f                    = '0;
    f[VALID_BIT]         = 1'b1;
    f[TAIL_BIT]          = 1'b1;
    f[DEST_MSB:DEST_LSB] = dest;
    f[VC_BIT]            = vc;
    f[NOC_DATA_W-1:0]    = data;
    return f;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with occupancy output; DEPTH must be a power of two so pointers wrap naturally.
module noc_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is left unreset; the pointers and level alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/noc_flit_injector.sv
// Buffers operator results and injects them as single-flit packets under per-VC credit flow control.
// Define NOC_INJ_VC_RR_EN to round-robin issue across VC0/VC1; otherwise every flit uses VC0.
module noc_flit_injector
  import noc_pkg::*;
#(
  parameter int DATA_W         = NOC_DATA_W,
  parameter int DEST_W         = NOC_DEST_W,
  parameter int NUM_NODES      = 9,
  parameter int CREDITS_PER_VC = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic [DEST_W-1:0]                 in_dest,
  output logic [FLIT_W-1:0]                 flit_out,
  output logic                              put_en,
  input  logic [1:0]                        credit_in,
  output logic                              credit_en,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              err_bad_dest,
  output logic                              err_credit_ovf
);

  localparam int              EW       = DEST_W + DATA_W;
  localparam int              CW       = $clog2(CREDITS_PER_VC + 1);
  localparam logic [CW-1:0]   CRED_MAX = CW'(CREDITS_PER_VC);
  localparam logic [DEST_W:0] NODES    = (DEST_W + 1)'(NUM_NODES);

  logic          run_q;
  credit_t       credit;
  logic          dest_ok;
  logic          accept;
  logic          push;
  logic          issue;
  logic          vc_sel;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] head;
  logic [CW-1:0] credit_cnt [2];
  logic [1:0]    inc;
  logic [1:0]    dec;
  logic [1:0]    ovf;

  assign credit    = credit_t'(credit_in);
  assign put_en    = run_q;
  assign credit_en = run_q;
  assign in_ready  = run_q & ~fifo_full;
  assign dest_ok   = ({1'b0, in_dest} < NODES);
  assign accept    = in_valid & in_ready;
  assign push      = accept & dest_ok;
  assign issue     = run_q & ~fifo_empty & (credit_cnt[vc_sel] != '0);

  noc_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .wdata ({in_dest, in_data}),
    .pop   (issue),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef NOC_INJ_VC_RR_EN
  logic turn_q;

  // Fall back to the other VC when the turn VC is starved; the turn itself only advances when it is used.
  always_comb begin
    vc_sel = turn_q;
    if (credit_cnt[turn_q] == '0 && credit_cnt[~turn_q] != '0) vc_sel = ~turn_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                       turn_q <= 1'b0;
    else if (issue && vc_sel == turn_q) turn_q <= ~turn_q;
  end
`else
  assign vc_sel = 1'b0;
`endif

  // NOTE: every output of this block gets a default before the loop so no latch is inferred.
  always_comb begin
    inc = '0;
    dec = '0;
    ovf = '0;
    for (int v = 0; v < 2; v++) begin
      inc[v] = run_q & credit.valid & (credit.vc == 1'(v));
      dec[v] = issue & (vc_sel == 1'(v));
      ovf[v] = inc[v] & ~dec[v] & (credit_cnt[v] == CRED_MAX);
    end
  end

  // A return and an issue on the same VC cancel; a return into a full counter saturates.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int v = 0; v < 2; v++) credit_cnt[v] <= CRED_MAX;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (dec[v] && !inc[v])                credit_cnt[v] <= credit_cnt[v] - CW'(1);
        else if (inc[v] && !dec[v] && !ovf[v]) credit_cnt[v] <= credit_cnt[v] + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run_q          <= 1'b0;
      flit_out       <= '0;
      err_bad_dest   <= 1'b0;
      err_credit_ovf <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept && !dest_ok) err_bad_dest   <= 1'b1;
      if (|ovf)               err_credit_ovf <= 1'b1;
      flit_out <= issue ? pack_flit(head[EW-1:DATA_W], vc_sel, head[DATA_W-1:0]) : '0;
    end
  end

endmodule
